sequenciador_exibicao: RTL

Sequencer that plays back the current round's stored sequence on the LEDs before the player's turn in the memory game. When the main control unit pulses `iniciar`, it walks memory addresses 0..`rodada`, showing each stored value on `leds` for `T_ON` cycles, then blanking for `T_OFF` cycles. It then reports completion with a one-cycle `pronto` pulse. It sits between the main control unit, which issues start and cancel, and the datapath sequence memory and LED outputs.

---
 rtl/sequenciador_exibicao.sv | 110 +++++++++++
 1 files changed

// File: rtl/sequenciador_exibicao.sv
// Plays back the stored sequence of the current round on the LEDs, one element per
// T_ON cycles followed by T_OFF blank cycles, then pulses pronto for one cycle.
module sequenciador_exibicao #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ativo,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t           estado, estado_prox;
    logic [ADDR_W-1:0] limite;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] padrao;
    logic              fim_on, fim_off, ultimo;

    assign fim_on    = (timer == TW'(T_ON - 1));
    assign fim_off   = (timer == TW'(T_OFF - 1));
    assign ultimo    = (endereco == limite);
    assign db_estado = estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    always_comb begin
        estado_prox = OCIOSO;
        leds        = '0;
        ativo       = 1'b1;
        pronto      = 1'b0;
        case (estado)
            OCIOSO: begin
                ativo       = 1'b0;
                estado_prox = iniciar ? CARREGA : OCIOSO;
            end
            CARREGA: estado_prox = ACENDE;
            ACENDE: begin
                leds        = padrao;
                estado_prox = fim_on ? APAGA : ACENDE;
            end
            APAGA:   estado_prox = fim_off ? (ultimo ? FIM : PROXIMO) : APAGA;
            PROXIMO: estado_prox = CARREGA;
            FIM: begin
                pronto      = 1'b1;
                estado_prox = OCIOSO;
            end
            default: begin
                ativo       = 1'b0;
                estado_prox = OCIOSO;
            end
        endcase
        // Abort overrides every transition, including a start in OCIOSO
        if (cancelar) estado_prox = OCIOSO;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            limite   <= '0;
            endereco <= '0;
            timer    <= '0;
            padrao   <= '0;
        end else if (cancelar) begin
            endereco <= '0;
            timer    <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        limite   <= rodada;
                        endereco <= '0;
                        timer    <= '0;
                    end
                end
                CARREGA: begin
                    padrao <= dado_mem;
                    timer  <= '0;
                end
                ACENDE:  timer <= fim_on ? '0 : timer + TW'(1);
                APAGA:   timer <= fim_off ? '0 : timer + TW'(1);
                PROXIMO: endereco <= endereco + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule
